ad_ip_jesd204_tpl_dac_framer: RTL and testbench
===============================================

Name: ad_ip_jesd204_tpl_dac_framer

Overview:
- Transport-layer framer for the JESD204 TX path; sits between the DAC channel datapath and the JESD204 TX link layer.
- Accepts per-channel converter samples with a valid/ready handshake and buffers them in a 2-entry skid FIFO.
- Pads each sample to BITS_PER_SAMPLE with zero tail bits and maps it into per-lane octet streams per JESD204 transport rules.
- Drives one beat per cycle whenever the link requests data; counts underflows.

Parameters:
- NUM_LANES, 1, number of JESD204 lanes (L).
- NUM_CHANNELS, 4, number of converters (M).
- BITS_PER_SAMPLE, 16, N'.
- CONVERTER_RESOLUTION, 14, N; must be <= BITS_PER_SAMPLE.
- SAMPLES_PER_FRAME, 1, S.
- OCTETS_PER_BEAT, 4, octets per lane per clk; must be a multiple of F.
- LINK_DATA_WIDTH, OCTETS_PER_BEAT*8*NUM_LANES, link bus width.
- DAC_DATA_WIDTH, LINK_DATA_WIDTH*CONVERTER_RESOLUTION/BITS_PER_SAMPLE, sample bus width.
- Derived: BPLF = BITS_PER_SAMPLE*SAMPLES_PER_FRAME*NUM_CHANNELS/NUM_LANES; F = BPLF/8; FRAMES_PER_BEAT = OCTETS_PER_BEAT*8/BPLF; SPC = FRAMES_PER_BEAT*SAMPLES_PER_FRAME (samples per channel per beat).

Ports:
- clk  in  1  link clock (line-rate/40).
- reset  in  1  synchronous, active-high reset.
- dac_enable  in  1  0 = mute and flush.
- dac_valid  in  1  dac_data valid.
- dac_ready  out  1  framer can accept a beat.
- dac_data  in  DAC_DATA_WIDTH  channel c sample k at [(c*SPC+k)*N +: N], two's complement.
- link_ready  in  1  link consumes link_data at this edge.
- link_data  out  LINK_DATA_WIDTH  lane n at [n*OCTETS_PER_BEAT*8 +: OCTETS_PER_BEAT*8], octet 0 (first transmitted) in bits [7:0].
- underflow_clr  in  1  clears underflow_count.
- underflow_count  out  16  saturating underflow counter.

Behaviour:
- Reset: FIFO count=0, started=0, link_data=0, underflow_count=0. dac_ready=1 the first cycle after reset if dac_enable=1.
- Mapping, applied combinationally to the FIFO head:
  - Channel c, sample k: frame f = k/S, position m = k%S.
  - Padded sample = {sample, (N'-N) zero bits}.
  - The frame bit stream is converter 0 samples 0..S-1, then converter 1, and so on; each sample is MSB first.
  - Lane n carries frame bits [n*BPLF, (n+1)*BPLF) in octets f*F..f*F+F-1 of that lane, MSB-first octets; the first octet holds the frame MSBs.
- FIFO: 2 entries.
  - dac_ready = dac_enable && (count != 2).
  - Push on dac_valid && dac_ready.
  - Pop on link_ready && count != 0. No write-through: a beat pushed at edge E cannot be popped before edge E+1.
  - Simultaneous push and pop leaves count unchanged; order is preserved.
- Output register: updates only at edges with link_ready=1; otherwise it holds.
  - count != 0: link_data <= framed(head).
  - count == 0: link_data <= 0, i.e. an underflow.
- Latency: beat accepted at edge E appears on link_data after edge E+1 if the FIFO was empty and link_ready=1.
- started is set on the first push after reset or after enable. Underflow is counted only when started && dac_enable.
- underflow_count:
  - +1 per underflow edge, saturating at 0xFFFF.
  - underflow_clr has priority: the counter becomes 0 even if an underflow occurs in the same cycle.
- dac_enable=0, synchronous:
  - count <= 0, started <= 0, link_data <= 0 every cycle regardless of link_ready.
  - dac_ready=0.
  - underflow_count is held.
- reset asserted mid-stream: all state returns to reset values at the next edge; FIFO contents are discarded.

Test Plan:
Configuration for all scenarios: L=1, M=2, N'=16, N=14, S=1, OCTETS_PER_BEAT=4, giving LINK_DATA_WIDTH=32 and DAC_DATA_WIDTH=28.
- Mapping: ch0=0x1ABC, ch1=0x0123 (dac_data=0x048DABC), link_ready=1 -> link_data=0x8C04F06A two edges after acceptance.
- Backpressure: link_ready=0, push 3 beats -> dac_ready goes low after 2 accepts. Then link_ready=1 -> beats emerge in order and dac_ready rises after the first pop.
- Underflow: one beat pushed, then dac_valid=0 with link_ready=1 for 5 cycles -> link_data=0 and underflow_count=4 (the first pop is not an underflow).
- Clear priority: underflow_clr asserted in an underflow cycle -> underflow_count=0. Forcing the counter to 0xFFFF -> it stays at 0xFFFF.
- Mute: dac_enable=0 with 2 entries buffered -> next cycle link_data=0, dac_ready=0, count=0. Re-enable with no pushes -> no underflow counted.
- Reset mid-stream: reset for 1 cycle with a full FIFO -> link_data=0, underflow_count=0, dac_ready=1.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_dac_framer.sv
// JESD204 TX transport-layer framer: 2-entry skid FIFO in front of a registered
// sample-to-octet mapper, with a saturating underflow counter.
module ad_ip_jesd204_tpl_dac_framer #(
  parameter int NUM_LANES            = 1,
  parameter int NUM_CHANNELS         = 4,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int CONVERTER_RESOLUTION = 14,
  parameter int SAMPLES_PER_FRAME    = 1,
  parameter int OCTETS_PER_BEAT      = 4,
  parameter int LINK_DATA_WIDTH      = OCTETS_PER_BEAT * 8 * NUM_LANES,
  parameter int DAC_DATA_WIDTH       = LINK_DATA_WIDTH * CONVERTER_RESOLUTION / BITS_PER_SAMPLE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dac_enable,
  input  logic                       dac_valid,
  output logic                       dac_ready,
  input  logic [DAC_DATA_WIDTH-1:0]  dac_data,
  input  logic                       link_ready,
  output logic [LINK_DATA_WIDTH-1:0] link_data,
  input  logic                       underflow_clr,
  output logic [15:0]                underflow_count
);

  localparam int BPLF            = BITS_PER_SAMPLE * SAMPLES_PER_FRAME * NUM_CHANNELS / NUM_LANES;
  localparam int F               = BPLF / 8;
  localparam int FRAMES_PER_BEAT = OCTETS_PER_BEAT * 8 / BPLF;
  localparam int SPC             = FRAMES_PER_BEAT * SAMPLES_PER_FRAME;
  localparam int FRAME_W         = BPLF * NUM_LANES;

  logic [DAC_DATA_WIDTH-1:0]  mem [2];
  logic                       wr_ptr, rd_ptr;
  logic [1:0]                 count;
  logic                       started;
  logic                       push, pop, underflow;
  logic [LINK_DATA_WIDTH-1:0] framed;

  assign dac_ready = dac_enable && (count != 2'd2);
  assign push      = dac_valid && dac_ready;
  // Pop looks at the pre-edge count, so a beat written this edge is never read this edge.
  assign pop       = link_ready && (count != 2'd0);
  assign underflow = link_ready && (count == 2'd0) && started && dac_enable;

  // Build each frame as one wide vector (converter 0 sample 0 in the MSBs),
  // then slice it into lanes and octets, first octet taken from the frame MSBs.
  always_comb begin
    logic [FRAME_W-1:0]         fv;
    logic [BITS_PER_SAMPLE-1:0] padded;
    // NOTE: every always_comb variable gets a default before any branch or loop, so no latch can be inferred.
    framed = '0;
    fv     = '0;
    padded = '0;
    for (int f = 0; f < FRAMES_PER_BEAT; f++) begin
      fv = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int m = 0; m < SAMPLES_PER_FRAME; m++) begin
          padded = '0;
          padded[BITS_PER_SAMPLE-1 -: CONVERTER_RESOLUTION] =
            mem[rd_ptr][(c*SPC + f*SAMPLES_PER_FRAME + m)*CONVERTER_RESOLUTION +: CONVERTER_RESOLUTION];
          fv[(NUM_CHANNELS*SAMPLES_PER_FRAME - 1 - (c*SAMPLES_PER_FRAME + m))*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] = padded;
        end
      end
      for (int n = 0; n < NUM_LANES; n++) begin
        for (int j = 0; j < F; j++) begin
          framed[n*OCTETS_PER_BEAT*8 + (f*F + j)*8 +: 8] = fv[(NUM_LANES-1-n)*BPLF + (F-1-j)*8 +: 8];
        end
      end
    end
  end

  // NOTE: FIFO storage carries no reset; validity is tracked by count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dac_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count           <= 2'd0;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      started         <= 1'b0;
      link_data       <= '0;
      underflow_count <= 16'd0;
    end else begin
      if (!dac_enable) begin
        count     <= 2'd0;
        wr_ptr    <= 1'b0;
        rd_ptr    <= 1'b0;
        started   <= 1'b0;
        link_data <= '0;
      end else begin
        if (push) begin
          wr_ptr  <= ~wr_ptr;
          started <= 1'b1;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
        if (link_ready) link_data <= (count != 2'd0) ? framed : '0;
      end
      if (underflow_clr)
        underflow_count <= 16'd0;
      else if (underflow && (underflow_count != 16'hFFFF))
        underflow_count <= underflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_framer.sv
// Directed self-checking bench for the framer in the L=1, M=2, N'=16, N=14, S=1 configuration.
module tb_ad_ip_jesd204_tpl_dac_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dac_enable;
  logic        dac_valid;
  logic        dac_ready;
  logic [27:0] dac_data;
  logic        link_ready;
  logic [31:0] link_data;
  logic        underflow_clr;
  logic [15:0] underflow_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed beats: {ch1, ch0} inputs and their framed lane words.
  localparam logic [27:0] BEAT_M = 28'h048DABC;  localparam logic [31:0] FRAME_M = 32'h8C04F06A;
  localparam logic [27:0] BEAT_A = 28'h0008001;  localparam logic [31:0] FRAME_A = 32'h08000400;
  localparam logic [27:0] BEAT_B = 28'h8003FFF;  localparam logic [31:0] FRAME_B = 32'h0080FCFF;
  localparam logic [27:0] BEAT_C = 28'h2AF1234;  localparam logic [31:0] FRAME_C = 32'hF02AD048;

  ad_ip_jesd204_tpl_dac_framer #(
    .NUM_LANES(1), .NUM_CHANNELS(2), .BITS_PER_SAMPLE(16), .CONVERTER_RESOLUTION(14),
    .SAMPLES_PER_FRAME(1), .OCTETS_PER_BEAT(4)
  ) dut (
    .clk(clk), .reset(reset), .dac_enable(dac_enable), .dac_valid(dac_valid),
    .dac_ready(dac_ready), .dac_data(dac_data), .link_ready(link_ready),
    .link_data(link_data), .underflow_clr(underflow_clr), .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; dac_enable = 1'b1; dac_valid = 1'b0; dac_data = '0;
    link_ready = 1'b0; underflow_clr = 1'b0;
    step(2);
    reset = 1'b0;
    check("reset_link_data", link_data, 32'h0);
    check("reset_uf_count", {16'h0, underflow_count}, 32'h0);
    check("reset_dac_ready", {31'h0, dac_ready}, 32'h1);

    // Mapping and two-edge latency
    link_ready = 1'b1; dac_valid = 1'b1; dac_data = BEAT_M;
    step();
    dac_valid = 1'b0;
    check("map_latency_e", link_data, 32'h0);
    step();
    link_ready = 1'b0;
    check("map_frame", link_data, FRAME_M);
    check("map_no_uf", {16'h0, underflow_count}, 32'h0);

    // Backpressure: third beat refused until the first pop
    dac_valid = 1'b1; dac_data = BEAT_A;
    check("bp_ready0", {31'h0, dac_ready}, 32'h1);
    step();
    dac_data = BEAT_B;
    check("bp_ready1", {31'h0, dac_ready}, 32'h1);
    step();
    dac_data = BEAT_C;
    check("bp_full", {31'h0, dac_ready}, 32'h0);
    step();
    check("bp_still_full", {31'h0, dac_ready}, 32'h0);
    check("bp_hold", link_data, FRAME_M);
    link_ready = 1'b1;
    step();
    check("bp_pop_a", link_data, FRAME_A);
    check("bp_ready_rise", {31'h0, dac_ready}, 32'h1);
    step();
    dac_valid = 1'b0;
    check("bp_pop_b", link_data, FRAME_B);
    step();
    link_ready = 1'b0;
    check("bp_pop_c", link_data, FRAME_C);
    check("bp_no_uf", {16'h0, underflow_count}, 32'h0);

    // Underflow: one beat then five link requests
    dac_valid = 1'b1; dac_data = BEAT_B;
    step();
    dac_valid = 1'b0; link_ready = 1'b1;
    step();
    check("uf_first_pop", link_data, FRAME_B);
    step(4);
    check("uf_link_zero", link_data, 32'h0);
    check("uf_count4", {16'h0, underflow_count}, 32'h4);

    // Clear wins over a same-cycle underflow, then counting resumes and saturates
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    check("clr_priority", {16'h0, underflow_count}, 32'h0);
    step(3);
    check("uf_resume", {16'h0, underflow_count}, 32'h3);
    step(65532);
    check("uf_reach_max", {16'h0, underflow_count}, 32'hFFFF);
    step(5);
    check("uf_saturate", {16'h0, underflow_count}, 32'hFFFF);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0; link_ready = 1'b0;
    check("clr_after_sat", {16'h0, underflow_count}, 32'h0);

    // Mute with a non-zero output and two beats buffered
    dac_valid = 1'b1; dac_data = BEAT_A;
    step();
    dac_data = BEAT_B;
    step();
    dac_valid = 1'b0; link_ready = 1'b1;
    step();
    link_ready = 1'b0; dac_valid = 1'b1; dac_data = BEAT_C;
    check("mute_pre_out", link_data, FRAME_A);
    step();
    dac_valid = 1'b0;
    check("mute_pre_full", {31'h0, dac_ready}, 32'h0);
    dac_enable = 1'b0;
    step();
    check("mute_link_zero", link_data, 32'h0);
    check("mute_ready0", {31'h0, dac_ready}, 32'h0);
    dac_enable = 1'b1; link_ready = 1'b1;
    step();
    check("reen_ready", {31'h0, dac_ready}, 32'h1);
    check("reen_flushed", link_data, 32'h0);
    step(3);
    check("reen_no_uf", {16'h0, underflow_count}, 32'h0);

    // Reset mid-stream with a full FIFO and a non-zero counter
    link_ready = 1'b0; dac_valid = 1'b1; dac_data = BEAT_A;
    step();
    dac_valid = 1'b0; link_ready = 1'b1;
    step(2);
    check("rst_pre_uf", {16'h0, underflow_count}, 32'h1);
    link_ready = 1'b0; dac_valid = 1'b1; dac_data = BEAT_B;
    step();
    dac_data = BEAT_C;
    step();
    dac_valid = 1'b0;
    check("rst_pre_full", {31'h0, dac_ready}, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_link_zero", link_data, 32'h0);
    check("rst_uf_zero", {16'h0, underflow_count}, 32'h0);
    check("rst_ready", {31'h0, dac_ready}, 32'h1);
    link_ready = 1'b1;
    step();
    link_ready = 1'b0;
    check("rst_discarded", link_data, 32'h0);
    check("rst_not_started", {16'h0, underflow_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
